// File: rtl/window_route_scheduler.sv
// Sequences the memory/routing kernel over a run of sliding windows and
// streams each routed window downstream on a valid/ready port.
module window_route_scheduler #(
    parameter int Depth     = 32,
    parameter int AddrWidth = $clog2(Depth),
    parameter int DataWidth = 8,
    parameter int MaxWidth  = 9,
    parameter int CntWidth  = 8,
    parameter int Timeout   = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [AddrWidth-1:0]          baseAddr,
    input  logic [AddrWidth-1:0]          stride,
    input  logic [AddrWidth-1:0]          windowWidth,
    input  logic [CntWidth-1:0]           numWindows,
    output logic                          routeEn,
    output logic [AddrWidth-1:0]          startAddr,
    output logic [AddrWidth-1:0]          inputWidth,
    input  logic                          finished,
    input  logic [MaxWidth*DataWidth-1:0] routedData,
    output logic [MaxWidth*DataWidth-1:0] winData,
    output logic                          winValid,
    input  logic                          winReady,
    output logic [CntWidth-1:0]           winIdx,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int TW = $clog2(Timeout) + 1;

    typedef enum logic [1:0] {IDLE, ROUTE, HOLD, GAP} stateT;

    stateT                state;
    logic [TW-1:0]        waitCnt;
    logic [AddrWidth-1:0] strideQ;
    logic [CntWidth-1:0]  numQ;
    logic                 badCfg;

    always_comb begin
        badCfg = (windowWidth == '0) || (32'(windowWidth) > 32'(MaxWidth)) || (numWindows == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            strideQ    <= '0;
            numQ       <= '0;
            routeEn    <= 1'b0;
            startAddr  <= '0;
            inputWidth <= '0;
            winData    <= '0;
            winValid   <= 1'b0;
            winIdx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (badCfg) begin
                            error <= 1'b1;
                        end else begin
                            strideQ    <= stride;
                            numQ       <= numWindows;
                            inputWidth <= windowWidth;
                            startAddr  <= baseAddr;
                            winIdx     <= '0;
                            waitCnt    <= '0;
                            routeEn    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ROUTE;
                        end
                    end
                end
                ROUTE: begin
                    if (finished) begin
                        winData  <= routedData;
                        winValid <= 1'b1;
                        routeEn  <= 1'b0;
                        state    <= HOLD;
                    end else if (waitCnt == TW'(Timeout - 1)) begin
                        // Kernel never answered: abandon the run without done.
                        error      <= 1'b1;
                        routeEn    <= 1'b0;
                        busy       <= 1'b0;
                        inputWidth <= '0;
                        state      <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (winReady) begin
                        winValid <= 1'b0;
                        if (winIdx == numQ - CntWidth'(1)) begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            inputWidth <= '0;
                            state      <= IDLE;
                        end else begin
                            winIdx    <= winIdx + CntWidth'(1);
                            startAddr <= startAddr + strideQ;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    routeEn <= 1'b1;
                    waitCnt <= '0;
                    state   <= ROUTE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_route_scheduler.sv
// Directed bench for window_route_scheduler: table-driven runs and bad configs,
// plus hand-written timeout and reset-mid-HOLD sequences.
module tb_window_route_scheduler;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MW = 9;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     baseAddr = '0;
    logic [AW-1:0]     stride = '0;
    logic [AW-1:0]     windowWidth = '0;
    logic [CW-1:0]     numWindows = '0;
    logic              routeEn;
    logic [AW-1:0]     startAddr;
    logic [AW-1:0]     inputWidth;
    logic              finished;
    logic [MW*DW-1:0]  routedData;
    logic [MW*DW-1:0]  winData;
    logic              winValid;
    logic              winReady = 1'b1;
    logic [CW-1:0]     winIdx;
    logic              busy;
    logic              done;
    logic              error;

    int passCnt = 0;
    int totalCnt = 0;
    int kDelay = 4;
    bit kNever = 1'b0;
    int kCnt;

    window_route_scheduler #(.Depth(32), .DataWidth(DW), .MaxWidth(MW), .CntWidth(CW), .Timeout(16)) dut (
        .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .stride(stride),
        .windowWidth(windowWidth), .numWindows(numWindows), .routeEn(routeEn),
        .startAddr(startAddr), .inputWidth(inputWidth), .finished(finished),
        .routedData(routedData), .winData(winData), .winValid(winValid),
        .winReady(winReady), .winIdx(winIdx), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [MW*DW-1:0] expData(input int addr);
        logic [MW*DW-1:0] d;
        d = '0;
        for (int i = 0; i < MW; i++) d[i*DW +: DW] = 8'(addr * 7 + i * 13 + 1);
        return d;
    endfunction

    // Kernel model: raises finished kDelay cycles into a routeEn request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            kCnt     <= 0;
            finished <= 1'b0;
        end else if (!routeEn || finished) begin
            kCnt     <= 0;
            finished <= 1'b0;
        end else begin
            kCnt <= kCnt + 1;
            if (!kNever && kCnt + 1 == kDelay) finished <= 1'b1;
        end
    end

    always_comb routedData = expData(int'(startAddr));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        int base; int stride; int width; int num; int stall;
        int a0; int a1; int a2;
    } runT;

    typedef struct { int width; int num; } badT;

    runT runs[4];
    badT bads[3];

    task automatic doRun(input runT r);
        int expA[3];
        int cnt;
        bit dropped;
        expA[0] = r.a0; expA[1] = r.a1; expA[2] = r.a2;
        @(negedge clk);
        start = 1'b1; baseAddr = AW'(r.base); stride = AW'(r.stride);
        windowWidth = AW'(r.width); numWindows = CW'(r.num); winReady = (r.stall == 0);
        @(negedge clk);
        // Scramble config so a late sample would be visible.
        start = 1'b0; baseAddr = 5'd17; stride = 5'd11; windowWidth = '0; numWindows = '0;
        chk("busyStart", busy, 1);
        chk("routeEnStart", routeEn, 1);
        chk("startAddr0", startAddr, expA[0]);
        chk("inputWidthBusy", inputWidth, r.width);
        chk("winIdx0", winIdx, 0);
        for (int w = 0; w < r.num; w++) begin
            cnt = 0; dropped = 1'b0;
            while (!winValid && cnt < 40) begin
                @(negedge clk);
                cnt++;
                if (!winValid && !routeEn) dropped = 1'b1;
            end
            chk("routeLatency", cnt, 5);
            chk("routeHeld", dropped, 0);
            chk("holdValid", winValid, 1);
            chk("holdRouteEn", routeEn, 0);
            chk("holdIdx", winIdx, w);
            chk("holdData", winData, expData(expA[w]));
            for (int s = 0; s < r.stall; s++) begin
                @(negedge clk);
                chk("stallValid", winValid, 1);
                chk("stallData", winData, expData(expA[w]));
                chk("stallIdx", winIdx, w);
                chk("stallRouteEn", routeEn, 0);
            end
            winReady = 1'b1;
            @(negedge clk);
            if (w == r.num - 1) begin
                chk("donePulse", done, 1);
                chk("busyDone", busy, 0);
                chk("inputWidthIdle", inputWidth, 0);
                chk("validDone", winValid, 0);
                @(negedge clk);
                chk("doneOneCycle", done, 0);
            end else begin
                chk("gapRouteEn", routeEn, 0);
                chk("gapValid", winValid, 0);
                chk("gapIdx", winIdx, w + 1);
                chk("gapAddr", startAddr, expA[w + 1]);
                chk("gapBusy", busy, 1);
                winReady = (r.stall == 0);
                @(negedge clk);
                chk("reissueRouteEn", routeEn, 1);
                chk("reissueAddr", startAddr, expA[w + 1]);
            end
        end
        winReady = 1'b1;
    endtask

    initial begin
        int cnt;
        bit sawDone;
        runs[0] = '{base: 0,  stride: 1, width: 5, num: 3, stall: 0, a0: 0,  a1: 1,  a2: 2};
        runs[1] = '{base: 30, stride: 3, width: 9, num: 3, stall: 0, a0: 30, a1: 1,  a2: 4};
        runs[2] = '{base: 5,  stride: 7, width: 1, num: 2, stall: 7, a0: 5,  a1: 12, a2: 0};
        runs[3] = '{base: 31, stride: 0, width: 3, num: 1, stall: 0, a0: 31, a1: 0,  a2: 0};
        bads[0] = '{width: 0,  num: 3};
        bads[1] = '{width: 10, num: 3};
        bads[2] = '{width: 5,  num: 0};

        @(negedge clk);
        chk("rstRouteEn", routeEn, 0);
        chk("rstBusy", busy, 0);
        chk("rstValid", winValid, 0);
        chk("rstAddr", startAddr, 0);
        chk("rstData", winData, 0);
        chk("rstDoneErr", {done, error}, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) doRun(runs[i]);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; baseAddr = '0; stride = 5'd1;
            windowWidth = AW'(bads[i].width); numWindows = CW'(bads[i].num);
            @(negedge clk);
            start = 1'b0;
            chk("badErr", error, 1);
            chk("badBusy", busy, 0);
            chk("badRouteEn", routeEn, 0);
            @(negedge clk);
            chk("badErrOneCycle", error, 0);
            chk("badRouteEnLater", routeEn, 0);
        end

        // Kernel that never finishes: expect timeout after 16 ROUTE cycles.
        kNever = 1'b1;
        @(negedge clk);
        start = 1'b1; baseAddr = 5'd2; stride = 5'd1; windowWidth = 5'd3; numWindows = 8'd2;
        @(negedge clk);
        start = 1'b0;
        chk("toRouteEn", routeEn, 1);
        cnt = 0; sawDone = 1'b0;
        while (!error && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (done) sawDone = 1'b1;
        end
        chk("toCycles", cnt, 16);
        chk("toRouteEnDrop", routeEn, 0);
        chk("toBusy", busy, 0);
        chk("toInputWidth", inputWidth, 0);
        chk("toNoDone", sawDone, 0);
        @(negedge clk);
        chk("toErrOneCycle", error, 0);
        kNever = 1'b0;

        // Reset while a window is held.
        winReady = 1'b0;
        @(negedge clk);
        start = 1'b1; baseAddr = 5'd3; stride = 5'd2; windowWidth = 5'd4; numWindows = 8'd3;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!winValid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("mrHoldReached", winValid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrValid", winValid, 0);
        chk("mrBusy", busy, 0);
        chk("mrRouteEn", routeEn, 0);
        chk("mrAddr", startAddr, 0);
        chk("mrWidth", inputWidth, 0);
        chk("mrIdx", winIdx, 0);
        chk("mrData", winData, 0);
        chk("mrDoneErr", {done, error}, 0);
        @(negedge clk);
        rst = 1'b0;
        winReady = 1'b1;
        doRun(runs[0]);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/window_route_scheduler.md
# window_route_scheduler

Sequencer that drives the memory/routing kernel through a run of sliding input windows. Given a base address, stride, window width and window count, it issues one route request per window, waits for the kernel's `finished`, captures the routed vector, and offers it downstream on a valid/ready port. It sits between the layer-level controller and `memory_kernel_top`, replacing manual `routeEn`/`startAddr` toggling.

## Interface
- `Depth`, 32: kernel buffer depth in words; power of two.
- `AddrWidth`, $clog2(Depth): buffer address width.
- `DataWidth`, 8: element width.
- `MaxWidth`, 9: max elements per routed window.
- `CntWidth`, 8: width of window count and window index.
- `Timeout`, 256: max cycles to wait for `finished` per window.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `baseAddr`  in  AddrWidth  start address of window 0.
- `stride`  in  AddrWidth  address increment between windows.
- `windowWidth`  in  AddrWidth  elements per window (1..MaxWidth).
- `numWindows`  in  CntWidth  windows in the run (>=1).
- `routeEn`  out  1  route request to kernel (level).
- `startAddr`  out  AddrWidth  kernel start address.
- `inputWidth`  out  AddrWidth  kernel window width.
- `finished`  in  1  kernel completion flag.
- `routedData`  in  MaxWidth*DataWidth  kernel `dataOut`.
- `winData`  out  MaxWidth*DataWidth  captured window.
- `winValid`  out  1  `winData` valid.
- `winReady`  in  1  downstream accepts.
- `winIdx`  out  CntWidth  index of current window.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after last window accepted.
- `error`  out  1  one-cycle pulse on bad config or timeout.

## Operation
- States: IDLE, ROUTE, HOLD, GAP.
- IDLE: on `start`=1, check config. `windowWidth`==0, `windowWidth`>MaxWidth or `numWindows`==0 -> pulse `error`, stay IDLE. Otherwise latch `stride`, `windowWidth`, `numWindows`; set `startAddr`=`baseAddr`, `winIdx`=0; go to ROUTE.
- ROUTE: `routeEn`=1; wait counter increments each cycle. On `finished`=1: capture `routedData` into `winData`, `routeEn`=0 next cycle, go to HOLD. If the counter reaches `Timeout` with no `finished`: pulse `error`, drop `routeEn`, return to IDLE (no `done`).
- HOLD: `winValid`=1; `winData` stable until handshake. On `winValid`&&`winReady`: if `winIdx`==`numWindows`-1, pulse `done` and go to IDLE. Otherwise `winIdx`+=1, `startAddr`=(`startAddr`+`stride`) mod Depth (truncating add), go to GAP.
- GAP: exactly one cycle with `routeEn`=0 so the kernel returns to its idle state. Then go to ROUTE.
- `inputWidth` = latched `windowWidth` whenever `busy`; 0 in IDLE.
- `start` outside IDLE is ignored. Config inputs are not sampled after the start cycle.
- `finished` is ignored outside ROUTE.

## Timing
- Reset (async, immediate): state IDLE. `routeEn`, `winValid`, `busy`, `done`, `error` = 0. `startAddr`, `inputWidth`, `winIdx` = 0. `winData` = 0. Wait counter = 0.
- `start` at edge N -> `routeEn`=1 and `busy`=1 from N+1.
- `finished` sampled at edge M -> `winValid`=1 from M+1, with `routeEn`=0 from M+1.
- Handshake at edge H, not last window -> GAP during H+1, `routeEn`=1 again from H+2 with the new `startAddr`.
- Handshake at edge H, last window -> `done`=1 during H+1 only, `busy`=0 from H+1. A new `start` is accepted at H+1.
- `winReady` may be held high permanently; minimum HOLD occupancy is 1 cycle.
- The wait counter resets on entering ROUTE. Timeout fires at edge where count==`Timeout`-1 with `finished`=0.
- `rst` mid-run aborts immediately; no `done` or `error` pulse.

## Test plan
- Base run: base=0, stride=1, width=5, num=3, kernel model finishes 4 cycles after `routeEn`, `winReady`=1. Required: `startAddr` 0,1,2 at the three issues; three `winValid` beats with `winIdx` 0,1,2; `done` pulses once; each GAP is exactly 1 cycle with `routeEn`=0.
- Wrap: base=30, stride=3, num=3. Required: `startAddr` sequence 30, 1, 4.
- Backpressure: `winReady`=0 for 7 cycles in HOLD. Required: `winData` and `winIdx` stable, `routeEn` stays 0, and the run advances only after `winReady`=1.
- Bad config: width=0, then width=10, then num=0, each with `start`. Required: `error` pulses for one cycle each, `busy` stays 0, and `routeEn` is never asserted.
- Timeout: `Timeout`=16, kernel never finishes. Required: `error` pulses at the 16th ROUTE cycle, `routeEn` drops, the block returns to IDLE, and `done` stays 0.
- Reset mid-HOLD: assert `rst` while `winValid`=1. Required: all outputs go to reset values immediately, and a subsequent `start` runs normally.
